// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the big-endian word data memory.
// Latency: read ack at grant+READ_LAT+1, write ack at grant+WRITE_LAT+2, misaligned ack at grant+1; busy stalls requesters.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t              state, state_nxt;
    logic                last_grant;
    logic                grant, grant_port;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                we_q, port_q, err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   p0_rdata_q, p1_rdata_q;

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_port = 1'b0;
        case (state)
            IDLE: begin
                if (p0_req && p1_req) begin
                    grant      = 1'b1;
                    grant_port = ~last_grant;
                end else if (p0_req) begin
                    grant      = 1'b1;
                    grant_port = 1'b0;
                end else if (p1_req) begin
                    grant      = 1'b1;
                    grant_port = 1'b1;
                end
                if (grant) begin
                    state_nxt = (sel_addr[1:0] != 2'b00) ? RESP : ACC;
                end
            end
            ACC:     if (cnt_q == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_we    = grant_port ? p1_we    : p0_we;
    assign sel_addr  = grant_port ? p1_addr  : p0_addr;
    assign sel_wdata = grant_port ? p1_wdata : p0_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            port_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                last_grant <= grant_port;
                port_q     <= grant_port;
                we_q       <= sel_we;
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
                err_q      <= (sel_addr[1:0] != 2'b00);
                cnt_q      <= sel_we ? CNT_W'(WRITE_LAT) : CNT_W'(READ_LAT - 1);
            end else if (state == ACC && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            // Read data is sampled on the last MemRead cycle of the window.
            if (state == ACC && !we_q && cnt_q == '0) begin
                if (port_q) p1_rdata_q <= read_data;
                else        p0_rdata_q <= read_data;
            end
        end
    end

    assign address    = addr_q;
    assign write_data = wdata_q;
    assign MemRead    = (state == ACC) && !we_q;
    assign MemWrite   = (state == ACC) && we_q && (cnt_q == '0);
    assign busy       = (state != IDLE);
    assign p0_ack     = (state == RESP) && !port_q;
    assign p1_ack     = (state == RESP) && port_q;
    assign p0_err     = p0_ack && err_q;
    assign p1_err     = p1_ack && err_q;
    assign p0_rdata   = p0_rdata_q;
    assign p1_rdata   = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small big-endian byte memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] address, write_data, read_data;
    logic        MemRead, MemWrite, busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:63];
    logic       seeded = 1'b0;
    int         rd_cycles = 0;
    int         wr_pulses = 0;
    int         rc0, wp0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(2), .WRITE_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .address(address), .write_data(write_data),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .read_data(read_data), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [5:0] base;
    assign base      = {address[5:2], 2'b00};
    assign read_data = {mem[base], mem[base + 6'd1], mem[base + 6'd2], mem[base + 6'd3]};

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[16] <= 8'h01; mem[17] <= 8'h23; mem[18] <= 8'h45; mem[19] <= 8'h67;
            seeded <= 1'b1;
        end else if (MemWrite) begin
            mem[base]        <= write_data[31:24];
            mem[base + 6'd1] <= write_data[23:16];
            mem[base + 6'd2] <= write_data[15:8];
            mem[base + 6'd3] <= write_data[7:0];
        end
        if (MemRead)  rd_cycles <= rd_cycles + 1;
        if (MemWrite) wr_pulses <= wr_pulses + 1;
    end

    function automatic logic [31:0] word_at(input int a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_memread", MemRead, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_acks", {p0_ack, p1_ack, p0_err, p1_err}, 0);
        check("rst_address", address, 0);
        check("rst_wdata", write_data, 0);
        check("rst_rdata", {p0_rdata ^ p1_rdata}, 0);
        reset = 1'b0;
        tick();

        // p0 aligned read of addr 16
        rc0 = rd_cycles;
        p0_req = 1; p0_we = 0; p0_addr = 16;
        tick();
        check("rd_t1_busy", busy, 1);
        check("rd_t1_memread", MemRead, 1);
        check("rd_t1_addr", address, 16);
        check("rd_t1_ack", p0_ack, 0);
        p0_req = 0;
        tick();
        check("rd_t2_memread", MemRead, 1);
        check("rd_t2_ack", p0_ack, 0);
        tick();
        check("rd_t3_ack", p0_ack, 1);
        check("rd_t3_p1ack", p1_ack, 0);
        check("rd_t3_err", p0_err, 0);
        check("rd_t3_rdata", p0_rdata, 32'h01234567);
        check("rd_t3_memread", MemRead, 0);
        check("rd_t3_busy", busy, 1);
        check("rd_cycles", rd_cycles - rc0, 2);
        tick();
        check("rd_t4_busy", busy, 0);
        check("rd_t4_ack", p0_ack, 0);
        check("rd_t4_hold", p0_rdata, 32'h01234567);

        // p1 aligned write of addr 4
        wp0 = wr_pulses;
        p1_req = 1; p1_we = 1; p1_addr = 4; p1_wdata = 32'hDEADBEEF;
        tick();
        check("wr_t1_memwrite", MemWrite, 0);
        check("wr_t1_memread", MemRead, 0);
        p1_req = 0;
        tick();
        check("wr_t2_memwrite", MemWrite, 1);
        check("wr_t2_addr", address, 4);
        check("wr_t2_wdata", write_data, 32'hDEADBEEF);
        check("wr_t2_ack", p1_ack, 0);
        tick();
        check("wr_t3_ack", p1_ack, 1);
        check("wr_t3_p0ack", p0_ack, 0);
        check("wr_t3_memwrite", MemWrite, 0);
        check("wr_mem", word_at(4), 32'hDEADBEEF);
        check("wr_pulses", wr_pulses - wp0, 1);
        tick();
        p1_req = 1; p1_we = 0; p1_addr = 4;
        tick();
        p1_req = 0;
        tick(); tick();
        check("rdback_ack", p1_ack, 1);
        check("rdback_rdata", p1_rdata, 32'hDEADBEEF);
        tick();

        // both ports read persistently: grants alternate p0, p1, p0, p1
        p0_req = 1; p0_we = 0; p0_addr = 16;
        p1_req = 1; p1_we = 0; p1_addr = 4;
        for (int k = 0; k < 4; k++) begin
            tick(); tick(); tick();
            check("rr_p0ack", p0_ack, (k % 2 == 0) ? 1 : 0);
            check("rr_p1ack", p1_ack, (k % 2 == 1) ? 1 : 0);
            if (k == 3) begin
                p0_req = 0; p1_req = 0;
            end
            tick();
            if (k < 3) check("rr_gap_busy", busy, 0);
        end
        check("rr_p0rdata", p0_rdata, 32'h01234567);
        check("rr_p1rdata", p1_rdata, 32'hDEADBEEF);

        // p0 misaligned write to addr 6
        rc0 = rd_cycles; wp0 = wr_pulses;
        p0_req = 1; p0_we = 1; p0_addr = 6; p0_wdata = 32'h11111111;
        tick();
        check("mis_ack", p0_ack, 1);
        check("mis_err", p0_err, 1);
        check("mis_p1", {p1_ack, p1_err}, 0);
        check("mis_busy", busy, 1);
        p0_req = 0;
        tick();
        check("mis_idle", {busy, p0_ack, p0_err}, 0);
        check("mis_mem", word_at(4), 32'hDEADBEEF);
        check("mis_strobes", (rd_cycles - rc0) + (wr_pulses - wp0), 0);

        // reset during ACC of a write, before MemWrite; last_grant is p0 here
        wp0 = wr_pulses;
        p0_req = 1; p0_we = 1; p0_addr = 8; p0_wdata = 32'hCAFEF00D;
        tick();
        check("abort_acc_busy", busy, 1);
        p0_req = 0; reset = 1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_strobes", {MemWrite, p0_ack, p1_ack}, 0);
        reset = 0;
        tick(); tick();
        check("abort_mem", word_at(8), 32'h00000000);
        check("abort_pulses", wr_pulses - wp0, 0);
        p0_req = 1; p0_we = 0; p0_addr = 16;
        p1_req = 1; p1_we = 0; p1_addr = 4;
        tick(); tick(); tick();
        check("abort_tie_p0", p0_ack, 1);
        check("abort_tie_p1", p1_ack, 0);
        p0_req = 0; p1_req = 0;
        tick();
        check("abort_done_busy", busy, 0);

        // p1 single-cycle pulse, then held req re-requests after its ack
        p1_req = 1; p1_we = 0; p1_addr = 16;
        tick();
        p1_req = 0;
        tick(); tick();
        check("pulse_ack", p1_ack, 1);
        check("pulse_rdata", p1_rdata, 32'h01234567);
        tick();
        p1_req = 1; p1_addr = 4;
        tick(); tick(); tick();
        check("held_ack1", p1_ack, 1);
        check("held_rdata1", p1_rdata, 32'hDEADBEEF);
        tick();
        check("held_gap", {busy, p1_ack}, 0);
        tick();
        check("held_restart", busy, 1);
        p1_req = 0;
        tick(); tick();
        check("held_ack2", p1_ack, 1);
        tick();
        check("held_end", {busy, p1_ack, p0_ack}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
